// File: rtl/cordic_job_ctrl_pkg.sv
// Shared types and constants for the CORDIC job sequencer.
// FSM encodings, float width and the NaN used for watchdog results.
package cordic_job_ctrl_pkg;

    localparam int FLOAT_W = 32;

    typedef logic [FLOAT_W-1:0] float_t;

    localparam float_t FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/cordic_fifo.sv
// Synchronous FIFO with first-word-fall-through head.
// Full refuses pushes even when a pop happens in the same cycle.
module cordic_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/cordic_job_ctrl.sv
// Sequences queued angle requests through a single CORDIC core,
// with a watchdog that turns a hung core into a flagged NaN result.
module cordic_job_ctrl
    import cordic_job_ctrl_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [FLOAT_W-1:0]         in_angle,
    output logic                       core_valid,
    output logic [FLOAT_W-1:0]         core_angle,
    input  logic                       core_done,
    input  logic [FLOAT_W-1:0]         core_sin,
    input  logic [FLOAT_W-1:0]         core_cos,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [FLOAT_W-1:0]         out_sin,
    output logic [FLOAT_W-1:0]         out_cos,
    output logic                       out_err,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t            state;
    logic [WD_W-1:0]   wd;
    logic [FLOAT_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              issue;

    assign in_ready = rst && !fifo_full;
    assign busy     = (state != IDLE) || !fifo_empty;

    // A pop only ever coincides with a move into ISSUE.
    assign issue = !fifo_empty &&
                   ((state == IDLE) || (state == HOLD && out_ready));

    cordic_fifo #(
        .WIDTH(FLOAT_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (in_valid && in_ready),
        .pop  (issue),
        .din  (in_angle),
        .head (fifo_head),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            wd         <= '0;
            core_valid <= 1'b0;
            core_angle <= '0;
            out_valid  <= 1'b0;
            out_sin    <= '0;
            out_cos    <= '0;
            out_err    <= 1'b0;
        end else begin
            core_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (issue) begin
                        core_angle <= fifo_head;
                        core_valid <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd    <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    wd <= wd + WD_W'(1);
                    if (core_done) begin
                        out_sin   <= core_sin;
                        out_cos   <= core_cos;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        out_sin   <= FP_QNAN;
                        out_cos   <= FP_QNAN;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (issue) begin
                            core_angle <= fifo_head;
                            core_valid <= 1'b1;
                            state      <= ISSUE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_job_ctrl.sv
// Self-checking bench for cordic_job_ctrl: vector table, directed
// corner sequences and a randomized run against a queue-based model.
module tb_cordic_job_ctrl;

    localparam int DEPTH = 4;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [31:0] PI4  = 32'h3F490FDB;
    localparam logic [31:0] R45  = 32'h3F3504F3;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_angle;
    logic        core_valid;
    logic [31:0] core_angle;
    logic        core_done;
    logic [31:0] core_sin;
    logic [31:0] core_cos;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sin;
    logic [31:0] out_cos;
    logic        out_err;
    logic        busy;
    logic [2:0]  count;

    int n_vec = 0;
    int n_bad = 0;

    logic        auto_done  = 1'b0;
    logic        force_done = 1'b0;
    logic [31:0] rsp_sin    = '0;
    logic [31:0] rsp_cos    = '0;
    int          core_lat   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] issue_q[$];

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] ang;
        logic        ordy;
        logic        e_ir;
        logic [2:0]  e_cnt;
        logic        e_busy;
        logic        e_cv;
        logic        e_ov;
    } vec_t;

    vec_t tbl[8];

    assign core_done = auto_done | force_done;
    assign core_sin  = rsp_sin;
    assign core_cos  = rsp_cos;

    cordic_job_ctrl #(
        .DEPTH  (DEPTH),
        .TIMEOUT(255)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_angle  (in_angle),
        .core_valid(core_valid),
        .core_angle(core_angle),
        .core_done (core_done),
        .core_sin  (core_sin),
        .core_cos  (core_cos),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sin   (out_sin),
        .out_cos   (out_cos),
        .out_err   (out_err),
        .busy      (busy),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_sin(input logic [31:0] a);
        return (a == PI4) ? R45 : (a ^ 32'h5A5A5A5A);
    endfunction

    function automatic logic [31:0] ref_cos(input logic [31:0] a);
        return (a == PI4) ? R45 : {a[15:0], a[31:16]};
    endfunction

    // Core model: done fires core_lat cycles after the start pulse;
    // core_lat 0 means never, negative means random 1..24.
    int          rsp_cnt = 0;
    logic [31:0] rsp_ang = '0;
    always @(negedge clk) begin
        auto_done = 1'b0;
        if (!rst) begin
            rsp_cnt = 0;
        end else if (core_valid) begin
            rsp_ang = core_angle;
            rsp_cnt = (core_lat < 0) ? int'($urandom_range(1, 24)) : core_lat;
        end else if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                auto_done = 1'b1;
                rsp_sin   = ref_sin(rsp_ang);
                rsp_cos   = ref_cos(rsp_ang);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got no event want event", name);
    endtask

    task automatic check_res(input string tag);
        logic [31:0] a;
        if (exp_q.size() == 0) begin
            miss({tag, "_extra"});
            return;
        end
        a = exp_q.pop_front();
        chk({tag, "_sin"}, out_sin, ref_sin(a));
        chk({tag, "_cos"}, out_cos, ref_cos(a));
        chk({tag, "_err"}, 32'(out_err), 32'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        force_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_core_valid", 32'(core_valid), 32'(0));
        chk("rst_core_angle", core_angle, 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_sin", out_sin, 32'(0));
        chk("rst_out_cos", out_cos, 32'(0));
        chk("rst_out_err", 32'(out_err), 32'(0));
        rst = 1'b1;
        exp_q.delete();
    endtask

    // Consume n results; with b2b set, every issue must follow the
    // previous output handshake by exactly one cycle.
    task automatic drain(input int n, input bit b2b);
        int got = 0;
        int c   = 0;
        int hs  = -1;
        out_ready = 1'b1;
        while (got < n) begin
            if (b2b && core_valid && hs >= 0) begin
                chk("b2b_gap", c - hs, 1);
            end
            if (out_valid) begin
                check_res("drain");
                hs = c;
                got++;
            end
            if (got < n) begin
                if (c >= 600) begin
                    miss("drain_budget");
                    return;
                end
                @(negedge clk);
                c++;
            end
        end
    endtask

    task automatic push1(input logic [31:0] a);
        in_valid = 1'b1;
        in_angle = a;
        #1;
        chk("push_ready", 32'(in_ready), 32'(1));
        exp_q.push_back(a);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic one_job(input logic [31:0] a, input int lat,
                           input int exp_ov, input bit exp_err);
        int ov_at = -1;
        int cv_at = -1;
        int cv_n  = 0;
        logic [31:0] es;
        logic [31:0] ec;
        es = exp_err ? QNAN : ref_sin(a);
        ec = exp_err ? QNAN : ref_cos(a);
        do_reset();
        core_lat = lat;
        in_valid = 1'b1;
        in_angle = a;
        for (int c = 1; c <= exp_ov + 5; c++) begin
            @(negedge clk);
            in_valid   = 1'b0;
            force_done = (c == exp_ov + 2);
            if (core_valid) begin
                cv_n++;
                if (cv_at < 0) cv_at = c;
            end
            if (out_valid && ov_at < 0) begin
                ov_at = c;
                chk("job_sin", out_sin, es);
                chk("job_cos", out_cos, ec);
                chk("job_err", 32'(out_err), 32'(exp_err));
            end
        end
        chk("job_cv_cycle", cv_at, 2);
        chk("job_cv_pulses", cv_n, 1);
        chk("job_ov_cycle", ov_at, exp_ov);
        chk("hold_valid", 32'(out_valid), 32'(1));
        chk("hold_sin", out_sin, es);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready  = 1'b0;
        force_done = 1'b1;
        chk("job_release", 32'(out_valid), 32'(0));
        @(negedge clk);
        force_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_spurious_ov", 32'(out_valid), 32'(0));
        chk("idle_spurious_busy", 32'(busy), 32'(0));
    endtask

    initial begin
        int acc;
        int iss;
        bit inflight;
        logic [31:0] a;

        rst        = 1'b0;
        in_valid   = 1'b0;
        in_angle   = '0;
        out_ready  = 1'b0;

        //             rst   iv    angle         ordy  ir    cnt   busy  cv    ov
        tbl[0] = '{1'b1, 1'b1, 32'h3F000001, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 32'h3F000002, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 32'h3F000003, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 32'h3F000004, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 32'h3F000005, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 32'h3F000006, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 32'h3F000006, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 32'h3F000006, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1};

        // Fill: five pushes with the output stalled, sixth refused.
        do_reset();
        core_lat = 3;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rst       = tbl[i].rst;
            in_valid  = tbl[i].iv;
            in_angle  = tbl[i].ang;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_core_valid", i), 32'(core_valid), 32'(tbl[i].e_cv));
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
        end
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(tbl[i].ang);
        end
        drain(5, 1'b1);
        @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("fill_end_count", 32'(count), 32'(0));
        chk("fill_end_busy", 32'(busy), 32'(0));
        chk("fill_end_ov", 32'(out_valid), 32'(0));

        // Single job, timeout, and done on the timeout cycle.
        one_job(PI4, 20, 23, 1'b0);
        one_job(32'h40490FDB, 0, 258, 1'b1);
        one_job(32'h3FC90FDB, 255, 258, 1'b0);

        // Push and pop in the same cycle at count 2.
        do_reset();
        core_lat = 3;
        in_valid = 1'b1;
        in_angle = 32'h11111111;
        @(negedge clk);
        in_angle = 32'h22222222;
        @(negedge clk);
        in_angle = 32'h33333333;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pp_count_before", 32'(count), 32'(2));
        chk("pp_out_valid", 32'(out_valid), 32'(1));
        exp_q.push_back(32'h11111111);
        check_res("pp_first");
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_angle  = 32'h44444444;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("pp_count_after", 32'(count), 32'(2));
        chk("pp_issue", 32'(core_valid), 32'(1));
        exp_q.push_back(32'h22222222);
        exp_q.push_back(32'h33333333);
        exp_q.push_back(32'h44444444);
        drain(3, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset while waiting on the core with three jobs queued.
        do_reset();
        core_lat = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_angle = 32'hC0000000 + 32'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("mid_count", 32'(count), 32'(3));
        chk("mid_busy", 32'(busy), 32'(1));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_count", 32'(count), 32'(0));
        chk("mrst_out_valid", 32'(out_valid), 32'(0));
        chk("mrst_busy", 32'(busy), 32'(0));
        chk("mrst_in_ready", 32'(in_ready), 32'(0));
        rst = 1'b1;
        @(negedge clk);
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("stale_out_valid", 32'(out_valid), 32'(0));
        chk("stale_busy", 32'(busy), 32'(0));

        // Ten sequential jobs walk the pointers around the ring.
        do_reset();
        core_lat = -1;
        for (int j = 0; j < 10; j++) begin
            push1($urandom);
            drain(1, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b0;

        // Randomized traffic against an order-preserving queue model.
        do_reset();
        core_lat = -1;
        acc      = 0;
        iss      = 0;
        inflight = 1'b0;
        issue_q.delete();
        #1;
        for (int t = 0; t < 1800; t++) begin
            if (core_valid) begin
                chk("rnd_one_in_flight", 32'(inflight), 32'(0));
                inflight = 1'b1;
                iss++;
                if (issue_q.size() == 0) begin
                    miss("rnd_issue_empty");
                end else begin
                    a = issue_q.pop_front();
                    chk("rnd_core_angle", core_angle, a);
                    exp_q.push_back(a);
                end
            end
            chk("rnd_count", 32'(count), acc - iss);
            chk("rnd_in_ready", 32'(in_ready), 32'((acc - iss) < DEPTH));
            out_ready = (t >= 1500) ? 1'b1 : ($urandom_range(0, 9) < 6);
            if (out_valid && out_ready) begin
                check_res("rnd_res");
                inflight = 1'b0;
            end
            in_valid = (t < 1500) && ($urandom_range(0, 1) == 1);
            in_angle = $urandom;
            if (in_valid && in_ready) begin
                issue_q.push_back(in_angle);
                acc++;
            end
            @(negedge clk);
            #1;
        end
        chk("rnd_left_issue", issue_q.size(), 0);
        chk("rnd_left_res", exp_q.size(), 0);
        chk("rnd_end_busy", 32'(busy), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
